// File: rtl/tdc_pkg.sv
// Shared constants for the TDC timestamp FIFO slice:
// register offsets, bit-field positions and default sizes.
package tdc_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int TS_W_DEF  = 32;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_TS     = 2'd1;
    localparam logic [1:0] REG_CHAN   = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_OVF   = 31;
    localparam int ST_FULL  = 8;
    localparam int ST_EMPTY = 7;

    localparam int CT_EN    = 0;
    localparam int CT_TH_LO = 4;

    function automatic logic [31:0] status_word(
        input logic       ovf,
        input logic       full,
        input logic       empty,
        input logic [6:0] cnt
    );
        logic [31:0] w;
        w           = '0;
        w[ST_OVF]   = ovf;
        w[ST_FULL]  = full;
        w[ST_EMPTY] = empty;
        w[6:0]      = cnt;
        return w;
    endfunction

    function automatic logic [31:0] ctrl_word(
        input logic       en,
        input logic [7:0] thresh
    );
        logic [31:0] w;
        w                       = '0;
        w[CT_EN]                = en;
        w[CT_TH_LO+7:CT_TH_LO]  = thresh;
        return w;
    endfunction

endpackage

// File: rtl/tdc_ts_fifo_if.sv
// Wishbone classic slave bundle for the timestamp FIFO.
// Signal names follow the slave-side view of the bus.
interface tdc_ts_fifo_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i,
        output wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i,
        input  wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/tdc_sync_fifo.sv
// Generic single-clock FIFO with flop storage.
// Push while full succeeds only if a pop happens the same cycle.
module tdc_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 34
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Occupancy changes only when exactly one side moves.
    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers and count; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Data array carries no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/tdc_ts_fifo.sv
// TDC event timestamp FIFO with Wishbone classic slave,
// sticky overflow flag and threshold interrupt.
module tdc_ts_fifo
    import tdc_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int TS_W  = TS_W_DEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    tdc_ts_fifo_if.slave     wb,
    input  logic             evt_valid_i,
    input  logic [TS_W-1:0]  evt_ts_i,
    input  logic [1:0]       evt_chan_i,
    output logic             irq_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = TS_W + 2;

    logic          ack_q, pop_pend_q, ovf_q, en_q, irq_q;
    logic [31:0]   dat_q, rdata;
    logic [7:0]    thresh_q;
    logic [EW-1:0] head;
    logic          full, empty;
    logic [CW-1:0] count;
    logic          req, wr, rd, push_req, drop;
    logic [1:0]    reg_sel;
    logic [31:0]   ts32;
    logic          unused_ok;

    assign req      = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q;
    assign wr       = req & wb.wbs_we_i;
    assign rd       = req & ~wb.wbs_we_i;
    assign reg_sel  = wb.wbs_adr_i[3:2];
    assign push_req = evt_valid_i & en_q;
    assign drop     = push_req & full & ~pop_pend_q;

    assign unused_ok = ^{wb.wbs_adr_i[31:4], wb.wbs_adr_i[1:0],
                         wb.wbs_sel_i[2], wb.wbs_dat_i[30:12],
                         wb.wbs_dat_i[3:1]};

    tdc_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (push_req),
        .pop_i   (pop_pend_q),
        .din_i   ({evt_chan_i, evt_ts_i}),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // Read mux; empty FIFO reads as zero on TS and CHAN.
    always_comb begin
        ts32  = empty ? '0 : 32'(head[TS_W-1:0]);
        rdata = '0;
        unique case (reg_sel)
            REG_STATUS: rdata = status_word(ovf_q, full, empty, 7'(count));
            REG_TS:     rdata = ts32;
            REG_CHAN:   rdata = empty ? '0 : {30'b0, head[EW-1:TS_W]};
            REG_CTRL:   rdata = ctrl_word(en_q, thresh_q);
            default:    rdata = '0;
        endcase
    end

    // Bus side: one-cycle ack, data only with ack, pop armed for ack cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            pop_pend_q <= 1'b0;
        end else begin
            ack_q      <= req;
            dat_q      <= rd ? rdata : '0;
            pop_pend_q <= rd & (reg_sel == REG_CHAN) & ~empty;
        end
    end

    // Control register with byte-lane writes.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            en_q     <= 1'b0;
            thresh_q <= '0;
        end else if (wr && reg_sel == REG_CTRL) begin
            if (wb.wbs_sel_i[0]) begin
                en_q          <= wb.wbs_dat_i[CT_EN];
                thresh_q[3:0] <= wb.wbs_dat_i[7:4];
            end
            if (wb.wbs_sel_i[1]) thresh_q[7:4] <= wb.wbs_dat_i[11:8];
        end
    end

    // Sticky overflow; a new drop wins over a same-cycle clear.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (wr && reg_sel == REG_STATUS &&
                     wb.wbs_sel_i[3] && wb.wbs_dat_i[ST_OVF]) begin
            ovf_q <= 1'b0;
        end
    end

    // Registered interrupt from overflow or occupancy threshold.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= ovf_q | (en_q & (8'(count) >= thresh_q) &
                              (thresh_q != 8'd0));
        end
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_tdc_ts_fifo.sv
// Directed self-checking bench for tdc_ts_fifo (DEPTH=8, TS_W=32).
// Expected values are hand-derived from the register map.
module tb_tdc_ts_fifo;

    logic        clk;
    logic        rst;
    logic        evt_valid;
    logic [31:0] evt_ts;
    logic [1:0]  evt_chan;
    logic        irq;

    int vectors;
    int miscompares;

    tdc_ts_fifo_if wb ();

    tdc_ts_fifo #(
        .DEPTH (8),
        .TS_W  (32)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wb          (wb),
        .evt_valid_i (evt_valid),
        .evt_ts_i    (evt_ts),
        .evt_chan_i  (evt_chan),
        .irq_o       (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input bit evt_in_ack, output logic [31:0] rdat);
        bit got;
        got  = 1'b0;
        rdat = '0;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_we_i  = we;
        wb.wbs_adr_i = adr;
        wb.wbs_dat_i = dat;
        wb.wbs_sel_i = sel;
        for (int n = 0; n < 8 && !got; n++) begin
            @(posedge clk);
            #1;
            if (wb.wbs_ack_o === 1'b1) begin
                got  = 1'b1;
                rdat = wb.wbs_dat_o;
            end
        end
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        if (got && evt_in_ack) evt_valid = 1'b1;
        @(posedge clk);
        #1;
        evt_valid = 1'b0;
        vectors++;
        assert (got) else begin
            miscompares++;
            $error("FAIL ack_timeout: observed no ack expected ack adr %h",
                   adr);
        end
    endtask

    task automatic rd(input logic [31:0] adr, output logic [31:0] d);
        xfer(1'b0, adr, 32'h0, 4'h0, 1'b0, d);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] d,
                      input logic [3:0] sel);
        logic [31:0] dummy;
        xfer(1'b1, adr, d, sel, 1'b0, dummy);
    endtask

    task automatic push(input logic [31:0] ts, input logic [1:0] ch);
        evt_valid = 1'b1;
        evt_ts    = ts;
        evt_chan  = ch;
        @(posedge clk);
        #1;
        evt_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        bit          seen;
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        evt_valid    = 1'b0;
        evt_ts       = '0;
        evt_chan     = '0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = '0;
        wb.wbs_dat_i = '0;
        wb.wbs_adr_i = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", {31'b0, wb.wbs_ack_o}, 32'h0);
        chk("rst_dat", wb.wbs_dat_o, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        rst = 1'b0;

        rd(32'h0, d);  chk("status_reset", d, 32'h0000_0080);
        rd(32'hC, d);  chk("ctrl_reset", d, 32'h0);
        wr(32'hC, 32'h1, 4'hF);
        rd(32'hC, d);  chk("ctrl_en", d, 32'h1);

        push(32'h100, 2'd1);
        push(32'h200, 2'd3);
        rd(32'h4, d);  chk("ts_head0", d, 32'h100);
        rd(32'h8, d);  chk("chan_pop0", d, 32'h1);
        rd(32'h4, d);  chk("ts_head1", d, 32'h200);
        rd(32'h0, d);  chk("status_cnt1", d, 32'h1);
        rd(32'h8, d);  chk("chan_pop1", d, 32'h3);
        rd(32'h0, d);  chk("status_empty", d, 32'h80);

        rd(32'h8, d);  chk("chan_empty", d, 32'h0);
        rd(32'h0, d);  chk("status_after_empty_pop", d, 32'h80);
        rd(32'h4, d);  chk("ts_empty", d, 32'h0);
        push(32'h55, 2'd2);
        rd(32'h4, d);  chk("ts_after_empty", d, 32'h55);
        rd(32'h8, d);  chk("chan_after_empty", d, 32'h2);

        for (int i = 0; i < 9; i++) push(32'h10 + i, 2'(i));
        chk("irq_not_yet", {31'b0, irq}, 32'h0);
        @(posedge clk);
        #1;
        chk("irq_ovf", {31'b0, irq}, 32'h1);
        rd(32'h0, d);  chk("status_ovf_full", d, 32'h8000_0108);
        wr(32'h0, 32'h8000_0000, 4'h8);
        rd(32'h0, d);  chk("status_ovf_clr", d, 32'h0000_0108);
        chk("irq_cleared", {31'b0, irq}, 32'h0);

        evt_ts   = 32'hABC;
        evt_chan = 2'd3;
        xfer(1'b0, 32'h8, 32'h0, 4'h0, 1'b1, d);
        chk("chan_full_pushpop", d, 32'h0);
        rd(32'h0, d);  chk("status_full_pushpop", d, 32'h108);
        for (int k = 1; k <= 8; k++) begin
            rd(32'h4, d);
            chk("drain_ts", d, (k < 8) ? 32'h10 + k : 32'hABC);
            rd(32'h8, d);
            chk("drain_chan", d, (k < 8) ? 32'(k % 4) : 32'h3);
        end
        rd(32'h0, d);  chk("status_drained", d, 32'h80);

        wr(32'hC, 32'h31, 4'hF);
        rd(32'hC, d);  chk("ctrl_thresh3", d, 32'h31);
        push(32'h301, 2'd0);
        push(32'h302, 2'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("irq_below_thr", {31'b0, irq}, 32'h0);
        push(32'h303, 2'd2);
        chk("irq_thr_lat", {31'b0, irq}, 32'h0);
        @(posedge clk);
        #1;
        chk("irq_thr_hit", {31'b0, irq}, 32'h1);
        rd(32'h8, d);  chk("chan_thr_pop", d, 32'h0);
        chk("irq_hold", {31'b0, irq}, 32'h1);
        @(posedge clk);
        #1;
        chk("irq_thr_drop", {31'b0, irq}, 32'h0);

        wr(32'h4, 32'hFFFF_FFFF, 4'hF);
        wr(32'h8, 32'hFFFF_FFFF, 4'hF);
        rd(32'h0, d);  chk("ro_writes_ignored", d, 32'h2);
        wr(32'hC, 32'h0000_0500, 4'h2);
        rd(32'hC, d);  chk("ctrl_sel_lane1", d, 32'h531);
        wr(32'hC, 32'h1, 4'hF);

        push(32'h304, 2'd3);
        push(32'h305, 2'd0);
        rd(32'h0, d);  chk("status_cnt4", d, 32'h4);
        wb.wbs_stb_i = 1'b1;
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_adr_i = 32'h8;
        #3;
        rst = 1'b1;
        #1;
        chk("rst_async_ack", {31'b0, wb.wbs_ack_o}, 32'h0);
        @(posedge clk);
        #1;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            if (wb.wbs_ack_o !== 1'b0) seen = 1'b1;
        end
        chk("no_ack_after_rst", {31'b0, seen}, 32'h0);
        rd(32'h0, d);  chk("status_post_rst", d, 32'h80);
        rd(32'hC, d);  chk("ctrl_post_rst", d, 32'h0);
        push(32'h400, 2'd1);
        rd(32'h0, d);  chk("en0_discard", d, 32'h80);
        wr(32'hC, 32'h1, 4'h1);
        push(32'h401, 2'd2);
        rd(32'h4, d);  chk("ts_post_rst", d, 32'h401);
        rd(32'h8, d);  chk("chan_post_rst", d, 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
